// File: rtl/pid_frame_ctrl.sv
// pid_frame_ctrl: initiator-side frame sequencer for the PID core start/done handshake.
// Build option: define PID_FRAME_ERR_SAT_EN to saturate the error subtraction on signed overflow.
module pid_frame_ctrl #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int OVR_W          = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [31:0]      period,
  input  logic [WIDTH-1:0] setpoint,
  input  logic [WIDTH-1:0] measurement,
  input  logic             meas_valid,
  input  logic             pid_done,
  input  logic [WIDTH-1:0] pid_out,
  output logic             start_calc,
  output logic [WIDTH-1:0] error,
  output logic [31:0]      delta_t,
  output logic [WIDTH-1:0] ctrl_out,
  output logic             ctrl_valid,
  output logic             busy,
  output logic             timeout_err,
  output logic [OVR_W-1:0] overrun_cnt
);

  // state     | meaning
  // S_IDLE    | waiting for a tick with a valid measurement
  // S_LAUNCH  | start_calc high for this single cycle
  // S_WAIT    | waiting for pid_done or timeout

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic [31:0]      r_cnt;
  logic [WIDTH-1:0] r_meas_q;
  logic             r_have_meas;
  logic [31:0]      r_stamp;
  logic             r_first_frame;
  logic [TMO_W-1:0] r_tmo;
  logic             r_start_calc;
  logic [WIDTH-1:0] r_error;
  logic [31:0]      r_delta_t;
  logic [WIDTH-1:0] r_ctrl_out;
  logic             r_ctrl_valid;
  logic             r_busy;
  logic             r_timeout_err;
  logic [OVR_W-1:0] r_ovr;

  logic [31:0]      w_period_m1;
  logic             w_tick;
  logic             w_have_meas;
  logic [WIDTH-1:0] w_meas;
  logic             w_launch;
  logic             w_drop;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_err;

  assign w_period_m1 = period - 32'd1;
  // Compare with >= so a shortened period wraps on the very next cycle.
  assign w_tick      = en && (period != 32'd0) && (r_cnt >= w_period_m1);

  // A measurement arriving with the tick is forwarded into that frame.
  assign w_have_meas = meas_valid | r_have_meas;
  assign w_meas      = meas_valid ? measurement : r_meas_q;

  assign w_launch    = (r_state == S_IDLE) && w_tick && w_have_meas;
  assign w_drop      = (r_state != S_IDLE) && w_tick;

  assign w_diff      = setpoint - w_meas;

`ifdef PID_FRAME_ERR_SAT_EN
  localparam logic [WIDTH-1:0] ERR_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ERR_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic w_ovf;

  // Overflow only when operand signs differ and the result sign flips away from setpoint.
  assign w_ovf = (setpoint[WIDTH-1] != w_meas[WIDTH-1]) &&
                 (w_diff[WIDTH-1] != setpoint[WIDTH-1]);
  assign w_err = w_ovf ? (setpoint[WIDTH-1] ? ERR_MIN : ERR_MAX) : w_diff;
`else
  assign w_err = w_diff;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (en) begin
      if ((period == 32'd0) || w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_meas_q    <= '0;
      r_have_meas <= 1'b0;
    end else if (en && meas_valid) begin
      r_meas_q    <= measurement;
      r_have_meas <= 1'b1;
    end
  end

  // Loaded so it reads 1 during the start_calc cycle; its value at the next
  // launching tick is then the number of enabled cycles between the two starts.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_stamp <= '0;
    end else if (en) begin
      if (w_launch) begin
        r_stamp <= 32'd1;
      end else if (r_stamp != '1) begin
        r_stamp <= r_stamp + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ovr <= '0;
    end else if (w_drop && (r_ovr != '1)) begin
      r_ovr <= r_ovr + OVR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= S_IDLE;
      r_first_frame <= 1'b1;
      r_tmo         <= '0;
      r_start_calc  <= 1'b0;
      r_error       <= '0;
      r_delta_t     <= '0;
      r_ctrl_out    <= '0;
      r_ctrl_valid  <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (en) begin
      r_start_calc <= 1'b0;
      r_ctrl_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_error       <= w_err;
            // All-ones on the first frame keeps the derivative term near zero.
            r_delta_t     <= r_first_frame ? 32'hFFFF_FFFF : r_stamp;
            r_first_frame <= 1'b0;
            r_start_calc  <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (pid_done) begin
            r_ctrl_out   <= pid_out;
            r_ctrl_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else if (r_tmo == TMO_LAST) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign start_calc  = r_start_calc & en;
  assign ctrl_valid  = r_ctrl_valid & en;
  assign error       = r_error;
  assign delta_t     = r_delta_t;
  assign ctrl_out    = r_ctrl_out;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_pid_frame_ctrl.sv
// Directed bench for pid_frame_ctrl: a frame-level reference model is stepped each clock
// and every output is compared after each rising edge, plus hand-computed literal checks.
module tb_pid_frame_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic [31:0] period;
  logic [31:0] setpoint;
  logic [31:0] measurement;
  logic        meas_valid;
  logic        pid_done;
  logic [31:0] pid_out;
  logic        start_calc;
  logic [31:0] error;
  logic [31:0] delta_t;
  logic [31:0] ctrl_out;
  logic        ctrl_valid;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  overrun_cnt;

  pid_frame_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(TMO), .OVR_W(8)) dut (
    .clk(clk), .nrst(nrst), .en(en), .period(period),
    .setpoint(setpoint), .measurement(measurement), .meas_valid(meas_valid),
    .pid_done(pid_done), .pid_out(pid_out),
    .start_calc(start_calc), .error(error), .delta_t(delta_t),
    .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid), .busy(busy),
    .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: a frame is "open" from its start until done/timeout;
  // m_age counts enabled cycles since the start (0 = the start_calc cycle).
  longint      m_cnt;
  bit          m_have;
  logic [31:0] m_meas;
  bit          m_first;
  bit          m_open;
  int          m_age;
  logic [31:0] m_err;
  logic [31:0] m_dt;
  logic [31:0] m_ctrl;
  bit          m_cv;
  bit          m_tmo;
  int          m_ovr;
  longint      m_ncyc;
  longint      m_last_start;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_error(input logic [31:0] sp, input logic [31:0] mv);
    longint d;
    d = longint'($signed(sp)) - longint'($signed(mv));
`ifdef PID_FRAME_ERR_SAT_EN
    if (d > 64'sd2147483647)  d = 64'sd2147483647;
    if (d < -64'sd2147483648) d = -64'sd2147483648;
`endif
    return d[31:0];
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_have = 0; m_meas = '0; m_first = 1; m_open = 0; m_age = 0;
    m_err = '0; m_dt = '0; m_ctrl = '0; m_cv = 0; m_tmo = 0; m_ovr = 0;
    m_ncyc = 0; m_last_start = 0;
  endtask

  task automatic model_step();
    bit          tick;
    bit          have;
    logic [31:0] mv;
    longint      gap;
    if (!en) return;
    tick = (period != 0) && (m_cnt >= longint'({32'b0, period}) - 1);
    m_cnt = (period == 0 || tick) ? 0 : m_cnt + 1;
    have = meas_valid || m_have;
    mv   = meas_valid ? measurement : m_meas;
    if (meas_valid) begin
      m_meas = measurement;
      m_have = 1;
    end
    m_cv = 0;
    if (m_open) begin
      if (tick && m_ovr < 255) m_ovr++;
      if (m_age >= 1 && pid_done) begin
        m_ctrl = pid_out; m_cv = 1; m_open = 0;
      end else if (m_age == TMO) begin
        m_tmo = 1; m_open = 0;
      end else begin
        m_age++;
      end
    end else if (tick && have) begin
      m_err = exp_error(setpoint, mv);
      gap   = m_ncyc + 1 - m_last_start;
      m_dt  = m_first ? 32'hFFFF_FFFF : ((gap > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : gap[31:0]);
      m_first = 0; m_open = 1; m_age = 0;
      m_last_start = m_ncyc + 1;
    end
    m_ncyc++;
  endtask

  task automatic compare_all();
    chk("start_calc",  start_calc,  (m_open && m_age == 0 && en));
    chk("error",       error,       m_err);
    chk("delta_t",     delta_t,     m_dt);
    chk("ctrl_out",    ctrl_out,    m_ctrl);
    chk("ctrl_valid",  ctrl_valid,  (m_cv && en));
    chk("busy",        busy,        m_open);
    chk("timeout_err", timeout_err, m_tmo);
    chk("overrun_cnt", overrun_cnt, m_ovr);
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs are compared
  // just after it, and control returns at the falling edge for new stimulus.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!nrst) model_reset();
    else model_step();
    compare_all();
    @(negedge clk);
  endtask

  task automatic wait_start(input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!start_calc && n < bound);
    chk("start_seen", start_calc, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int s1, s2, s3, s4, s5;
    int nstart;

    nrst = 0; en = 1; period = 32'd10; setpoint = 32'd250; measurement = 32'd100;
    meas_valid = 0; pid_done = 0; pid_out = '0;
    model_reset();
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_delta_t", delta_t, 0);

    // Frame 1: first tick at count 9 -> start on the 10th edge after release.
    nrst = 1; meas_valid = 1;
    step();
    meas_valid = 0;
    wait_start(30, n);
    s1 = cyc;
    chk("first_start_latency", n + 1, 10);
    chk("first_error", error, 150);
    chk("first_delta_t", delta_t, 32'hFFFF_FFFF);
    chk("first_busy", busy, 1);

    repeat (3) step();
    pid_done = 1; pid_out = 32'h1234;
    step();
    pid_done = 0;
    chk("capture_valid", ctrl_valid, 1);
    chk("capture_value", ctrl_out, 32'h1234);
    step();
    chk("valid_one_cycle", ctrl_valid, 0);

    wait_start(30, n);
    s2 = cyc;
    chk("frame_spacing", s2 - s1, 10);
    chk("second_delta_t", delta_t, 10);

    repeat (2) step();
    pid_done = 1; pid_out = 32'hFFFF_FFFB;
    step();
    pid_done = 0;
    chk("capture2_value", ctrl_out, 32'hFFFF_FFFB);
    repeat (2) step();

    // Count is 5, above new period-1 = 4: next edge must tick.
    period = 32'd5;
    wait_start(4, n);
    s3 = cyc;
    chk("period_shrink_tick", n, 1);

    n = 0;
    do begin
      step();
      n++;
    end while (!timeout_err && n < 40);
    chk("timeout_latency", n, 17);
    chk("timeout_flag", timeout_err, 1);
    chk("timeout_overruns", overrun_cnt, 3);
    chk("timeout_ctrl_kept", ctrl_out, 32'hFFFF_FFFB);
    chk("timeout_no_valid", ctrl_valid, 0);

    wait_start(10, n);
    s4 = cyc;
    chk("resume_spacing", s4 - s3, 20);

    // Done on the 16th waiting cycle, the same cycle the timeout would fire.
    repeat (16) step();
    pid_done = 1; pid_out = 32'h0000_0ABC;
    step();
    pid_done = 0;
    chk("done_wins_valid", ctrl_valid, 1);
    chk("done_wins_value", ctrl_out, 32'h0000_0ABC);

    wait_start(10, n);
    s5 = cyc;
    period = 32'd0;
    repeat (5) step();
    en = 0;
    repeat (50) step();
    chk("frozen_busy", busy, 1);
    chk("frozen_start", start_calc, 0);
    en = 1;
    repeat (5) step();
    pid_done = 1; pid_out = 32'h55AA;
    step();
    pid_done = 0;
    chk("post_freeze_valid", ctrl_valid, 1);
    chk("post_freeze_value", ctrl_out, 32'h55AA);
    chk("post_freeze_span", cyc - s5, 61);

    // Positive overflow, measurement forwarded into the tick it arrives with.
    setpoint = 32'h7FFF_FFFF; measurement = 32'hFFFF_FFFF; meas_valid = 1; period = 32'd1;
    wait_start(3, n);
    meas_valid = 0;
`ifdef PID_FRAME_ERR_SAT_EN
    chk("pos_overflow_error", error, 32'h7FFF_FFFF);
`else
    chk("pos_overflow_error", error, 32'h8000_0000);
`endif
    step();
    pid_done = 1; pid_out = 32'h0;
    step();
    pid_done = 0;
    setpoint = 32'h8000_0000; measurement = 32'h1; meas_valid = 1;
    wait_start(3, n);
    meas_valid = 0;
`ifdef PID_FRAME_ERR_SAT_EN
    chk("neg_overflow_error", error, 32'h8000_0000);
`else
    chk("neg_overflow_error", error, 32'h7FFF_FFFF);
`endif

    repeat (400) step();
    chk("overrun_saturated", overrun_cnt, 255);

    n = 0;
    while (!(busy && !start_calc) && n < 20) begin
      step();
      n++;
    end
    chk("busy_before_reset", busy, 1);
    #2 nrst = 0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_timeout", timeout_err, 0);
    chk("async_rst_overrun", overrun_cnt, 0);
    chk("async_rst_ctrl_out", ctrl_out, 0);
    chk("async_rst_error", error, 0);
    step();
    nrst = 1; period = 32'd3;
    nstart = 0;
    repeat (20) begin
      step();
      if (start_calc) nstart++;
    end
    chk("no_start_without_meas", nstart, 0);
    meas_valid = 1;
    wait_start(10, n);
    meas_valid = 0;
    chk("post_reset_delta_t", delta_t, 32'hFFFF_FFFF);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
